// File: rtl/add4_seq_ctrl.sv
// add4_seq_ctrl: sequences a WIDTH=4*NIBBLES bit add over one external 4-bit ripple adder (add4).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, ready, done    request / idle / one-cycle completion pulse
//   op_a, op_b, cin       operands and carry-in, sampled on the accepting edge
//   sum, cout             registered result, updated only when done is entered
//   add_a, add_b, add_cin drive to the external add4 (zero outside RUN)
//   add_sum, add_cout     result from the external add4
//   sub                   only with ADD4_SEQ_CTRL_SUB_EN defined: 1 = compute op_a - op_b
//
// Optional feature macro: ADD4_SEQ_CTRL_SUB_EN
module add4_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef ADD4_SEQ_CTRL_SUB_EN
    input  logic                 sub,
`endif
    output logic                 ready,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [NIBBLES-1:0][3:0]   a_q, a_d, b_q, b_d, work_q, work_d;
    logic                      carry_q, carry_d;
    logic [4*NIBBLES-1:0]      sum_q, sum_d;
    logic                      cout_q, cout_d;
    logic [4*NIBBLES-1:0]      op_b_eff;
    logic                      cin_eff;
    logic                      run;

`ifdef ADD4_SEQ_CTRL_SUB_EN
    // Subtraction is two's complement: A + ~B + 1.
    assign op_b_eff = sub ? ~op_b : op_b;
    assign cin_eff  = sub | cin;
`else
    assign op_b_eff = op_b;
    assign cin_eff  = cin;
`endif

    assign run     = (state_q == RUN);
    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign add_a   = run ? a_q[idx_q] : 4'd0;
    assign add_b   = run ? b_q[idx_q] : 4'd0;
    assign add_cin = run & carry_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == IDLE && start) begin
            a_d     = op_a;
            b_d     = op_b_eff;
            carry_d = cin_eff;
            idx_d   = '0;
            state_d = RUN;
        end else if (run) begin
            work_d[idx_q] = add_sum;
            carry_d       = add_cout;
            if (idx_q == IW'(NIBBLES - 1)) begin
                // Publish the whole word, including the nibble captured on this edge.
                sum_d   = work_d;
                cout_d  = add_cout;
                state_d = DONE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
endmodule

// File: tb/tb_add4_seq_ctrl.sv
// tb_add4_seq_ctrl: self-checking bench for add4_seq_ctrl with a behavioural add4 attached.
module tb_add4_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         cin = 1'b0;
    logic         ready, done, cout;
    logic [W-1:0] sum;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;
`ifdef ADD4_SEQ_CTRL_SUB_EN
    logic         sub = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_sum = '0;

    always #5 clk = ~clk;

    // The external add4 block.
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    add4_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef ADD4_SEQ_CTRL_SUB_EN
        .sub(sub),
`endif
        .ready(ready), .done(done), .sum(sum), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full operation: checks the per-nibble adder drive, carry chain,
    // sum hold during RUN, the done pulse timing and the final result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s, input logic [W-1:0] exp_s, input logic exp_c);
        logic [W-1:0] be;
        logic         carry;
        logic [4:0]   t;
        be    = s ? ~b : b;
        carry = s ? 1'b1 : c;
        @(negedge clk);
        chk("ready_before", 32'(ready), 1);
        start = 1'b1; op_a = a; op_b = b; cin = c;
`ifdef ADD4_SEQ_CTRL_SUB_EN
        sub = s;
`endif
        @(posedge clk); #1;
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        for (int k = 0; k < N; k++) begin
            chk("run_ready", 32'(ready), 0);
            chk("run_done", 32'(done), 0);
            chk("add_a", 32'(add_a), 32'(a[4*k +: 4]));
            chk("add_b", 32'(add_b), 32'(be[4*k +: 4]));
            chk("add_cin", 32'(add_cin), 32'(carry));
            chk("sum_hold", 32'(sum), 32'(prev_sum));
            t = 5'(a[4*k +: 4]) + 5'(be[4*k +: 4]) + 5'(carry);
            carry = t[4];
            @(posedge clk); #1;
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_ready", 32'(ready), 0);
        chk("sum", 32'(sum), 32'(exp_s));
        chk("cout", 32'(cout), 32'(exp_c));
        chk("idle_adder", 32'({add_a, add_b, add_cin}), 0);
        prev_sum = exp_s;
        @(posedge clk); #1;
        chk("done_end", 32'(done), 0);
        chk("ready_back", 32'(ready), 1);
        chk("sum_kept", 32'(sum), 32'(exp_s));
    endtask

    vec_t tbl[6];

    initial begin
        logic [W:0]   m;
        logic [W-1:0] ra, rb;
        logic         rc;
        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        tbl[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        #1;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_adder", 32'({add_a, add_b, add_cin}), 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, 1'b0, tbl[i].s, tbl[i].co);

        // start held through RUN and DONE: ignored, then accepted on first IDLE edge.
        @(negedge clk);
        start = 1'b1; op_a = 16'h00FF; op_b = 16'h0001; cin = 1'b0;
        @(posedge clk); #1;
        op_a = 16'h1111; op_b = 16'h1111;
        for (int k = 0; k < N; k++) begin
            chk("hold_run_done", 32'(done), 0);
            @(posedge clk); #1;
        end
        chk("hold_done", 32'(done), 1);
        chk("hold_sum1", 32'(sum), 32'h0100);
        chk("hold_cout1", 32'(cout), 0);
        @(posedge clk); #1;
        chk("hold_idle", 32'(ready), 1);
        chk("hold_nodone", 32'(done), 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_accepted", 32'(ready), 0);
        for (int k = 0; k < N; k++) begin
            chk("hold_run2_done", 32'(done), 0);
            @(posedge clk); #1;
        end
        chk("hold_done2", 32'(done), 1);
        chk("hold_sum2", 32'(sum), 32'h2222);
        @(posedge clk); #1;
        prev_sum = 16'h2222;

        // Asynchronous reset during the second RUN cycle.
        @(negedge clk);
        start = 1'b1; op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_add_a", 32'(add_a), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready), 1);
        chk("arst_done", 32'(done), 0);
        chk("arst_sum", 32'(sum), 0);
        chk("arst_cout", 32'(cout), 0);
        chk("arst_adder", 32'({add_a, add_b, add_cin}), 0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk); #1;
            chk("arst_no_done", 32'(done), 0);
            chk("arst_sum_zero", 32'(sum), 0);
        end
        prev_sum = '0;
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);

`ifdef ADD4_SEQ_CTRL_SUB_EN
        run_op(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);
`endif

        // Random operations against plain-arithmetic reference.
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            m = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            run_op(ra, rb, rc, 1'b0, m[W-1:0], m[W]);
        end
`ifdef ADD4_SEQ_CTRL_SUB_EN
        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            m = (W+1)'(ra) - (W+1)'(rb);
            run_op(ra, rb, 1'b0, 1'b1, m[W-1:0], ra >= rb);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
